hi_fanout_sink: RTL and testbench
=================================

Name: hi_fanout_sink

Overview:
- Checker stage directly downstream of the high-fanout driver/load array.
- Collects the Q outputs of every load flop on the fanned-out net and confirms each one equals the driver value from the previous cycle.
- Counts and records mismatches through a pipelined reduction tree, so the checker adds no deep combinational cone of its own.
- Used to confirm functional equivalence after fanout repair (buffer insertion and load splitting) across hierarchy.

Parameters:
- NUM_LOADS, 70, number of load-flop Q bits checked (two children of 35).
- GROUP, 8, bits per first-level reduction group; the last group may be partial.
- CNT_W, 16, width of the mismatch counter.
- IDX_W, 7, width of the failing-load index; must be at least clog2(NUM_LOADS).

Ports:
- clk1  in  1  single clock, rising edge; same clock as driver and loads.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  check enable.
- clr  in  1  synchronous clear of err_cnt, err_sticky and first_idx.
- a  in  1  driver net value (driver Q).
- q  in  NUM_LOADS  load-flop Q outputs; bit i comes from load i.
- busy  out  1  state != IDLE.
- err_pulse  out  1  registered, one cycle per mismatching sample.
- err_sticky  out  1  set on first mismatch, held until clr or reset.
- err_cnt  out  CNT_W  saturating mismatch count.
- first_idx  out  IDX_W  lowest failing load index of the first mismatching sample.

Behaviour:
- Reset (rst_n=0, asynchronous): all state and pipeline registers clear; all outputs 0; FSM enters IDLE. Applies mid-pipeline; in-flight samples are discarded.
- Expected-value register: a_d <= a every edge, so a_d holds the driver value the loads captured on the same edge.
- FSM states:
  - IDLE -> ARM when en=1.
  - ARM -> CHECK when en=1; ARM -> IDLE when en=0. The ARM sample is never checked because a_d is stale.
  - CHECK -> IDLE when en=0.
  - Sample valid v0 = (state==CHECK) & en.
- Pipeline (q presented before edge E0):
  - E0: d_r <= q XOR {NUM_LOADS{a_d}}; v1 <= v0.
  - E1: per-group any-mismatch bit plus local lowest-index of set bit; v2 <= v1. Pad the partial last group with 0s, so padding never mismatches.
  - E2: mismatch <= v2 & OR(group bits); idx2 <= global lowest failing index (lowest group wins); err_pulse <= that mismatch.
  - E3: counter and sticky update.
  - err_pulse is high the cycle after E2; err_cnt and err_sticky change after E3.
- Counter: increments by 1 per mismatching sample and saturates at 2^CNT_W-1 (no wrap).
- first_idx loads idx2 only when a mismatch occurs while err_sticky=0; it holds thereafter.
- clr=1 clears err_cnt, err_sticky and first_idx. clr has priority over a same-cycle increment (result 0). clr does not flush the pipeline; samples already in flight still report afterwards.
- Deasserting en stops new samples at v0; samples already in v1 and v2 complete normally.
- Multiple failing bits in one sample count as 1 mismatch.

Test Plan:
- Reset, en=1, a toggling each cycle, q = previous a on all 70 bits for 100 cycles -> err_cnt=0, err_sticky=0, err_pulse never high.
- Same stimulus, invert q[41] on one CHECK cycle -> err_pulse high 3 edges later for one cycle; err_cnt=1; err_sticky=1; first_idx=41.
- One sample with q[69] and q[3] both wrong, then a later sample with q[10] wrong -> err_cnt=2; first_idx=3.
- CNT_W=4 with 20 consecutive mismatching samples -> err_cnt saturates at 15. clr on the same cycle as an increment -> err_cnt=0 and err_sticky=0.
- Raise en with mismatching q on the ARM cycle only -> no error counted; busy=1 from the cycle after en rises.
- Assert rst_n=0 mid-stream with a mismatch in v1 -> outputs 0 immediately, no pulse after release, FSM in IDLE.

Source files
------------

// File: rtl/hi_fanout_sink.sv
// Fanout-equivalence checker: compares every load-flop Q against the driver value
// from the previous cycle and reports mismatches through a pipelined reduction tree.
module hi_fanout_sink #(
    parameter int NUM_LOADS = 70,
    parameter int GROUP     = 8,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = 7
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 a,
    input  logic [NUM_LOADS-1:0] q,
    output logic                 busy,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [IDX_W-1:0]     first_idx
);

    localparam int NGRP   = (NUM_LOADS + GROUP - 1) / GROUP;
    localparam int PAD_W  = NGRP * GROUP;
    localparam int LIDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic                     busy_r;
    logic                     v0_s;
    logic                     a_d_r;
    logic [NUM_LOADS-1:0]     d_r;
    logic                     v1_r;
    logic [PAD_W-1:0]         pad_s;
    logic [NGRP-1:0]          grp_any_s;
    logic [NGRP*LIDX_W-1:0]   grp_idx_s;
    logic [NGRP-1:0]          grp_any_r;
    logic [NGRP*LIDX_W-1:0]   grp_idx_r;
    logic                     v2_r;
    logic [IDX_W-1:0]         gidx_s;
    logic                     mis_r;
    logic [IDX_W-1:0]         idx2_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     sticky_r;
    logic [IDX_W-1:0]         first_idx_r;

    // FSM state register; busy is registered from the next state
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Next-state logic: ARM spends one cycle letting a_d catch up with the loads
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = en ? ARM : IDLE;
            ARM:     state_nxt_s = en ? CHECK : IDLE;
            CHECK:   state_nxt_s = en ? CHECK : IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    assign v0_s = (state_r == CHECK) & en;

    // Stage E0: expected-value register and raw per-load mismatch vector
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            a_d_r <= 1'b0;
            d_r   <= '0;
            v1_r  <= 1'b0;
        end else begin
            a_d_r <= a;
            d_r   <= q ^ {NUM_LOADS{a_d_r}};
            v1_r  <= v0_s;
        end
    end

    // Per-group OR and local lowest set bit; zero padding never reports a mismatch
    always_comb begin
        pad_s     = '0;
        grp_any_s = '0;
        grp_idx_s = '0;
        for (int i = 0; i < NUM_LOADS; i++) begin
            pad_s[i] = d_r[i];
        end
        for (int g = 0; g < NGRP; g++) begin
            grp_any_s[g] = |pad_s[g*GROUP +: GROUP];
            for (int j = GROUP - 1; j >= 0; j--) begin
                grp_idx_s[g*LIDX_W +: LIDX_W] = pad_s[g*GROUP + j] ? LIDX_W'(j)
                                                                   : grp_idx_s[g*LIDX_W +: LIDX_W];
            end
        end
    end

    // Stage E1: register group summaries
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            grp_any_r <= '0;
            grp_idx_r <= '0;
            v2_r      <= 1'b0;
        end else begin
            grp_any_r <= grp_any_s;
            grp_idx_r <= grp_idx_s;
            v2_r      <= v1_r;
        end
    end

    // Global lowest failing index: the lowest failing group wins
    always_comb begin
        gidx_s = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            gidx_s = grp_any_r[g] ? (IDX_W'(g*GROUP) + IDX_W'(grp_idx_r[g*LIDX_W +: LIDX_W]))
                                  : gidx_s;
        end
    end

    // Stage E2: one mismatch flag per sample regardless of how many bits failed
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mis_r  <= 1'b0;
            idx2_r <= '0;
        end else begin
            mis_r  <= v2_r & (|grp_any_r);
            idx2_r <= gidx_s;
        end
    end

    // Stage E3: saturating counter, sticky flag and first index; clr wins
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= '0;
            sticky_r    <= 1'b0;
            first_idx_r <= '0;
        end else if (clr) begin
            cnt_r       <= '0;
            sticky_r    <= 1'b0;
            first_idx_r <= '0;
        end else if (mis_r) begin
            cnt_r       <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            sticky_r    <= 1'b1;
            first_idx_r <= sticky_r ? first_idx_r : idx2_r;
        end else begin
            cnt_r       <= cnt_r;
            sticky_r    <= sticky_r;
            first_idx_r <= first_idx_r;
        end
    end

    assign busy       = busy_r;
    assign err_pulse  = mis_r;
    assign err_sticky = sticky_r;
    assign err_cnt    = cnt_r;
    assign first_idx  = first_idx_r;

endmodule

// File: tb/tb_hi_fanout_sink.sv
// Scoreboard bench for hi_fanout_sink: stimulus pushes expected mismatch events,
// a negedge monitor pops them and tracks counter/sticky/index expectations.
module tb_hi_fanout_sink;

    localparam int N  = 70;
    localparam int CW = 4;
    localparam int IW = 7;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          a = 1'b0;
    logic [N-1:0]  q = '0;
    logic          busy;
    logic          err_pulse;
    logic          err_sticky;
    logic [CW-1:0] err_cnt;
    logic [IW-1:0] first_idx;

    hi_fanout_sink #(.NUM_LOADS(N), .GROUP(8), .CNT_W(CW), .IDX_W(IW)) dut (
        .clk1(clk1), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .q(q),
        .busy(busy), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .first_idx(first_idx)
    );

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    typedef struct {
        int due;
        int idx;
    } rec_t;
    rec_t sbq[$];
    bit   en_hist [0:8191];
    bit   clr_hist[0:8191];

    int   checks = 0;
    int   errors = 0;
    int   run = 0;
    logic a_prev = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] m;
        m = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    // One cycle of stimulus; a sample counts when en has been high for 3+ cycles
    task automatic drive(bit e, bit c, bit av, logic [N-1:0] mask);
        int lo;
        @(posedge clk1);
        #1;
        en  = e;
        clr = c;
        a   = av;
        q   = {N{a_prev}} ^ mask;
        run = e ? run + 1 : 0;
        en_hist[cyc+1]  = e;
        clr_hist[cyc+1] = c;
        if (e && run >= 3 && mask != '0) begin
            lo = -1;
            for (int i = N - 1; i >= 0; i--) if (mask[i]) lo = i;
            sbq.push_back('{cyc + 3, lo});
        end
        a_prev = av;
    endtask

    task automatic do_reset(int hold);
        @(posedge clk1);
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk1);
            #1;
            en = 1'b0; clr = 1'b0; a = 1'b0; q = '0;
            en_hist[cyc+1]  = 1'b0;
            clr_hist[cyc+1] = 1'b0;
        end
        @(posedge clk1);
        #2;
        rst_n  = 1'b1;
        run    = 0;
        a_prev = 1'b0;
    endtask

    // Monitor / reference model
    initial begin
        logic          pend;
        int            pend_idx;
        logic          exp_p;
        int            eidx;
        logic [CW-1:0] m_cnt;
        logic          m_st;
        logic [IW-1:0] m_idx;
        rec_t          r;
        pend = 1'b0; pend_idx = 0; m_cnt = '0; m_st = 1'b0; m_idx = '0;
        forever begin
            @(negedge clk1);
            if (!rst_n) begin
                sbq.delete();
                pend = 1'b0; m_cnt = '0; m_st = 1'b0; m_idx = '0;
                chk("rst_busy", busy, 0);
                chk("rst_err_pulse", err_pulse, 0);
                chk("rst_err_sticky", err_sticky, 0);
                chk("rst_err_cnt", err_cnt, 0);
                chk("rst_first_idx", first_idx, 0);
            end else begin
                if (clr_hist[cyc]) begin
                    m_cnt = '0; m_st = 1'b0; m_idx = '0;
                end else if (pend) begin
                    if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
                    if (!m_st) m_idx = IW'(pend_idx);
                    m_st = 1'b1;
                end
                exp_p = 1'b0; eidx = 0;
                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    r = sbq.pop_front();
                    exp_p = 1'b1;
                    eidx = r.idx;
                end
                chk("err_pulse", err_pulse, exp_p);
                chk("busy", busy, en_hist[cyc]);
                chk("err_cnt", err_cnt, m_cnt);
                chk("err_sticky", err_sticky, m_st);
                chk("first_idx", first_idx, m_idx);
                pend = exp_p; pend_idx = eidx;
            end
        end
    end

    // Stimulus
    initial begin
        logic [N-1:0] m;
        repeat (3) @(posedge clk1);
        #2 rst_n = 1'b1;

        // clean toggling stream
        for (int k = 0; k < 100; k++) drive(1'b1, 1'b0, ~a_prev, '0);
        // single failing load 41
        drive(1'b1, 1'b0, ~a_prev, onehot(41));
        repeat (6) drive(1'b1, 1'b0, ~a_prev, '0);
        drive(1'b1, 1'b1, ~a_prev, '0);
        repeat (3) drive(1'b1, 1'b0, ~a_prev, '0);
        // two failing bits in one sample, then another sample
        drive(1'b1, 1'b0, ~a_prev, onehot(69) | onehot(3));
        repeat (3) drive(1'b1, 1'b0, ~a_prev, '0);
        drive(1'b1, 1'b0, ~a_prev, onehot(10));
        repeat (6) drive(1'b1, 1'b0, ~a_prev, '0);
        // saturation
        for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, ~a_prev, onehot($urandom_range(N-1, 0)));
        repeat (5) drive(1'b1, 1'b0, ~a_prev, '0);
        // clr coinciding with an increment
        drive(1'b1, 1'b0, ~a_prev, onehot(55));
        drive(1'b1, 1'b0, ~a_prev, '0);
        drive(1'b1, 1'b0, ~a_prev, '0);
        drive(1'b1, 1'b1, ~a_prev, '0);
        repeat (4) drive(1'b1, 1'b0, ~a_prev, '0);
        // mismatches only on IDLE/ARM cycles after en rises
        repeat (3) drive(1'b0, 1'b0, ~a_prev, '0);
        drive(1'b1, 1'b0, ~a_prev, onehot(7));
        drive(1'b1, 1'b0, ~a_prev, onehot(20));
        repeat (6) drive(1'b1, 1'b0, ~a_prev, '0);
        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            m = '0;
            if ($urandom_range(4, 0) == 0) begin
                if ($urandom_range(1, 0) == 0) m = onehot($urandom_range(N-1, 0));
                else m = N'({$urandom, $urandom, $urandom});
            end
            drive(($urandom_range(7, 0) != 0), ($urandom_range(39, 0) == 0),
                  1'($urandom_range(1, 0)), m);
        end
        // reset with a mismatch sitting in the pipeline
        repeat (4) drive(1'b1, 1'b0, ~a_prev, '0);
        drive(1'b1, 1'b0, ~a_prev, onehot(33));
        do_reset(3);
        repeat (10) drive(1'b0, 1'b0, ~a_prev, '0);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
